// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: default frame width,
// capture state encoding and a pointer-width helper.
package uart_pkg;

  localparam int unsigned DEF_FRAME_WIDTH = 8;

  typedef enum logic [1:0] {
    CAP_IDLE   = 2'b00,
    CAP_SHIFT  = 2'b01,
    CAP_COMMIT = 2'b10
  } cap_state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers.
// A write to a full FIFO is accepted when a read frees a slot in the same cycle.
module rx_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);
  assign count = wr_ptr - rd_ptr;

  // Stale entries are never exposed, so the array itself needs no reset.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/rx_frame_buffer.sv
// UART receive frame buffer: deserializes LSB-first mid-bit samples, commits
// complete frames into a FIFO and keeps sticky framing/overrun status.
module rx_frame_buffer
  import uart_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH = DEF_FRAME_WIDTH,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx_sample,
  input  logic                         shift_en,
  input  logic                         frame_start,
  input  logic                         frame_done,
  input  logic                         frame_err,
  output logic [FRAME_WIDTH-1:0]       rd_data,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                         overrun,
  output logic                         framing_err,
  input  logic                         status_clr
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_WIDTH);

  cap_state_t             state;
  cap_state_t             state_nxt;
  logic [FRAME_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   push;
  logic                   pop;
  logic                   set_ferr;
  logic                   set_ovr;
  logic                   fifo_full;
  logic                   fifo_empty;

  assign rd_valid = !fifo_empty;
  assign pop      = rd_valid && rd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CAP_IDLE;
    else     state <= state_nxt;
  end

  // frame_start restarts from any state; frame_err outranks frame_done.
  always_comb begin
    state_nxt = state;
    if (frame_start) begin
      state_nxt = CAP_SHIFT;
    end else begin
      case (state)
        CAP_SHIFT: begin
          if (frame_err)       state_nxt = CAP_IDLE;
          else if (frame_done) state_nxt = CAP_COMMIT;
        end
        CAP_COMMIT: state_nxt = CAP_IDLE;
        default:    state_nxt = CAP_IDLE;
      endcase
    end
  end

  always_comb begin
    push     = 1'b0;
    set_ferr = 1'b0;
    set_ovr  = 1'b0;
    case (state)
      CAP_SHIFT: set_ferr = frame_err && !frame_start;
      CAP_COMMIT: begin
        if (bit_cnt != FULL_CNT)     set_ferr = 1'b1;
        else if (fifo_full && !pop)  set_ovr  = 1'b1;
        else                         push     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (frame_start) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (state == CAP_SHIFT && shift_en && bit_cnt < FULL_CNT) begin
      shreg   <= {rx_sample, shreg[FRAME_WIDTH-1:1]};
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun     <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      if (set_ovr)         overrun <= 1'b1;
      else if (status_clr) overrun <= 1'b0;
      if (set_ferr)        framing_err <= 1'b1;
      else if (status_clr) framing_err <= 1'b0;
    end
  end

  rx_sync_fifo #(
    .WIDTH (FRAME_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (shreg),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule
